tisc_mc_datapath: RTL and testbench
===================================

// Module: tisc_mc_datapath
// PURPOSE
//  Parametrised multi-cycle TISC datapath: PC, register file, ALU, control FSM; instruction/data memories external via req/ack.
//  Executes one instruction per FETCH-DECODE-EXEC-[MEM]-WB pass.
//  Adds branches, immediates, flags, halt and wait-states to the fixed 8-bit single-cycle datapath.
//  Sits between progmem/datamem wrappers and the top-level core.
// PARAMETERS
//  DATA_W  8  register/ALU/data-memory word width
//  PC_W    8  program counter width; imem address width
//  RA_W    4  register address width; 2**RA_W registers; dmem address width = 2*RA_W
//  OPC_W   4  opcode width; instruction width INSTR_W = OPC_W+3*RA_W (localparam)
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          async active-low reset
//  start       in   1          leave IDLE/HALT, begin fetching at current PC
//  imem_req    out  1          instruction fetch request
//  imem_addr   out  PC_W       fetch address (= PC)
//  imem_ack    in   1          imem_rdata valid this cycle
//  imem_rdata  in   INSTR_W    instruction word
//  dmem_req    out  1          data access request
//  dmem_we     out  1          1 = store, 0 = load
//  dmem_addr   out  2*RA_W     data address {ra,rb}
//  dmem_wdata  out  DATA_W     store data (= R[rd])
//  dmem_ack    in   1          access complete; dmem_rdata valid for loads
//  dmem_rdata  in   DATA_W     load data
//  pc          out  PC_W       current PC
//  opcode      out  OPC_W      opcode of latched instruction
//  busy        out  1          FSM not in IDLE/HALT
//  halted      out  1          FSM in HALT
//  illegal     out  1          sticky: undefined opcode executed
// BEHAVIOUR
//  Format: [INSTR_W-1 -: OPC_W]=op, then rd, ra, rb (RA_W each, MSB first); imm/target = {ra,rb}.
//  Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR (rd<=ra op rb); 6 LD rd<=M[imm]; 7 ST M[imm]<=rd;
//   8 LDI rd<=imm (zero-ext/trunc to DATA_W); 9 BEQZ: if R[rd]==0 PC<=target; 10 JMP PC<=target; 15 HALT.
//   Others: NOP, set illegal.
//  Target zero-extended/truncated to PC_W.
//  Reset: state IDLE, PC=0, all regs=0, flags Z=C=0, all outputs 0, illegal=0.
//  FSM: IDLE -start-> FETCH.
//   FETCH: imem_req=1 until imem_ack; latch instr -> DECODE.
//   DECODE: read R[ra],R[rb],R[rd] -> EXEC.
//   EXEC: ALU/branch resolve; LD/ST -> MEM, HALT -> HALT, else -> WB.
//   MEM: dmem_req=1, addr/we/wdata held stable until dmem_ack -> WB.
//   WB: write rd (ALU, LD, LDI only); PC update; -> FETCH.
//   HALT: -start-> FETCH at PC+1.
//  PC: PC+1 in WB unless branch taken/JMP; wraps 2**PC_W-1 -> 0.
//  Latency with same-cycle acks: ALU/LDI/branch 4 cycles; LD/ST 5 cycles; +1 per ack wait.
//  ALU: results mod 2**DATA_W.
//   ADD: C=carry-out. SUB: C=borrow (ra<rb).
//   Logic ops: C=0. Z=(result==0). Z/C update only on ops 1-5.
//  Register 0 is general-purpose (not hardwired).
//  Same rd read and written in one instr: reads use pre-write value.
//  imem_ack/dmem_ack outside FETCH/MEM ignored.
//  start while busy ignored.
//  rst_n low at any time: immediate return to reset values; req lines drop asynchronously; outstanding access abandoned.
// TESTING
//  1 LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT, acks same cycle -> R3=8, Z=0, C=0, halted after 4+4+4+4 cycles, pc=3.
//  2 LDI R1,0xFF; LDI R2,1; ADD R3,R1,R2 -> R3=0x00, Z=1, C=1. SUB R4,R2,R1 -> R4=0x02, C=1.
//  3 ST R1,[0x40] then LD R5,[0x40], dmem_ack delayed 3 cycles -> req/addr/wdata stable 4 cycles, R5=R1, LD takes 8 cycles.
//  4 BEQZ R0,0x10 with R0=0 -> pc=0x10; R0=1 -> pc+1. JMP 0x00 from PC=0xFF -> pc=0x00. Plain PC wrap 0xFF -> 0x00.
//  5 rst_n low mid-MEM with dmem_req=1 -> dmem_req=0 same cycle, pc=0, regs=0, IDLE; start after release fetches addr 0.
//  6 opcode 0xC -> illegal=1 sticky, regs unchanged, execution continues; start during busy -> no effect.

Source files
------------

// File: rtl/tisc_mc_datapath.sv
// Multi-cycle TISC datapath: PC, register file, ALU and control FSM.
// Instruction and data memories are external and use a req/ack handshake.
`timescale 1ns/1ps
module tisc_mc_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned RA_W   = 4,
  parameter int unsigned OPC_W  = 4,
  localparam int unsigned INSTR_W = OPC_W + 3*RA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [2*RA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [OPC_W-1:0]   opcode,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  localparam int unsigned DA_W = 2*RA_W;
  localparam int unsigned NREG = 2**RA_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_BEQZ = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(15);

  logic [2:0]         state, state_nxt;
  logic [INSTR_W-1:0] instr;
  logic [OPC_W-1:0]   op;
  logic [RA_W-1:0]    rd_f, ra_f, rb_f;
  logic [DA_W-1:0]    imm;
  logic [DATA_W-1:0]  regs [NREG];
  logic [DATA_W-1:0]  opa, opb, opd, res;
  logic               wr_en, br_taken, flag_z, flag_c;
  logic [DATA_W:0]    alu_sum;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_c, alu_flags;

  assign op        = instr[INSTR_W-1 -: OPC_W];
  assign rd_f      = instr[3*RA_W-1 -: RA_W];
  assign ra_f      = instr[2*RA_W-1 -: RA_W];
  assign rb_f      = instr[RA_W-1:0];
  assign imm       = instr[DA_W-1:0];
  assign imem_addr = pc;
  assign opcode    = op;

  // ALU on the operands latched in DECODE
  always_comb begin
    alu_sum   = '0;
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_flags = 1'b0;
    case (op)
      OP_ADD: begin
        alu_sum   = {1'b0, opa} + {1'b0, opb};
        alu_res   = alu_sum[DATA_W-1:0];
        alu_c     = alu_sum[DATA_W];
        alu_flags = 1'b1;
      end
      OP_SUB: begin
        alu_sum   = {1'b0, opa} - {1'b0, opb};
        alu_res   = alu_sum[DATA_W-1:0];
        alu_c     = alu_sum[DATA_W];
        alu_flags = 1'b1;
      end
      OP_AND: begin alu_res = opa & opb; alu_flags = 1'b1; end
      OP_OR:  begin alu_res = opa | opb; alu_flags = 1'b1; end
      OP_XOR: begin alu_res = opa ^ opb; alu_flags = 1'b1; end
      default: ;
    endcase
  end

  // Control FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_LD || op == OP_ST) state_nxt = S_MEM;
        else if (op == OP_HALT)         state_nxt = S_HALT;
        else                            state_nxt = S_WB;
      end
      S_MEM:    if (dmem_ack) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Status and handshake outputs follow the next state so they are valid on state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      imem_req <= (state_nxt == S_FETCH);
      dmem_req <= (state_nxt == S_MEM);
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
      halted   <= (state_nxt == S_HALT);
    end
  end

  // Datapath: instruction latch, operand read, execute, memory, write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr      <= '0;
      opa        <= '0;
      opb        <= '0;
      opd        <= '0;
      res        <= '0;
      wr_en      <= 1'b0;
      br_taken   <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      illegal    <= 1'b0;
      pc         <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ack) instr <= imem_rdata;
        S_DECODE: begin
          opa <= regs[ra_f];
          opb <= regs[rb_f];
          opd <= regs[rd_f];
        end
        S_EXEC: begin
          wr_en    <= 1'b0;
          br_taken <= 1'b0;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              res   <= alu_res;
              wr_en <= 1'b1;
            end
            OP_LD:   wr_en <= 1'b1;
            OP_LDI: begin
              res   <= DATA_W'(imm);
              wr_en <= 1'b1;
            end
            OP_BEQZ: br_taken <= (opd == '0);
            OP_JMP:  br_taken <= 1'b1;
            OP_NOP, OP_ST, OP_HALT: ;
            default: illegal <= 1'b1;
          endcase
          if (alu_flags) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
          end
          if (op == OP_LD || op == OP_ST) begin
            dmem_we    <= (op == OP_ST);
            dmem_addr  <= imm;
            dmem_wdata <= opd;
          end
        end
        S_MEM: if (dmem_ack && !dmem_we) res <= dmem_rdata;
        S_WB: begin
          if (wr_en) regs[rd_f] <= res;
          pc <= br_taken ? PC_W'(imm) : pc + PC_W'(1);
        end
        S_HALT: if (start) pc <= pc + PC_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tisc_mc_datapath.sv
// Directed bench for tisc_mc_datapath with behavioural instruction/data memories.
`timescale 1ns/1ps
module tb_tisc_mc_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  pc;
  logic [3:0]  opcode;
  logic        busy, halted, illegal;

  tisc_mc_datapath dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .opcode(opcode), .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [7:0]  dm  [256];
  int          dly = 0;
  int          wcnt = 0;
  int          cyc_cnt = 0;
  logic [7:0]  fa [$];
  int          ft [$];
  int          lens [$];
  logic        unstable = 1'b0;
  logic [7:0]  cap_addr, cap_wdata;
  logic        cap_we;
  int          req_len = 0;
  int          passed = 0;
  int          total = 0;

  assign imem_ack   = imem_req;
  assign imem_rdata = rom[imem_addr];
  assign dmem_ack   = dmem_req && (wcnt == dly);
  assign dmem_rdata = dm[dmem_addr];

  // Memory models and bus monitors
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (imem_req && imem_ack) begin fa.push_back(imem_addr); ft.push_back(cyc_cnt); end
    if (dmem_req) begin
      if (req_len == 0) begin cap_addr <= dmem_addr; cap_wdata <= dmem_wdata; cap_we <= dmem_we; end
      else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata || dmem_we !== cap_we) unstable <= 1'b1;
      if (dmem_ack) begin
        lens.push_back(req_len + 1);
        req_len <= 0;
        if (dmem_we) dm[dmem_addr] <= dmem_wdata;
      end else begin
        req_len <= req_len + 1;
      end
    end else begin
      req_len <= 0;
    end
    wcnt <= (dmem_req && !dmem_ack) ? wcnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse start and count edges (start edge included) until halted; optional second start at 'kick'
  task automatic run(input int kick, output int cyc);
    fa.delete(); ft.delete(); lens.delete();
    @(negedge clk); start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); cyc++; #1;
      start = (cyc == kick);
    end while (!halted && cyc < 2000);
    start = 1'b0;
    check("halt_reached", 32'(halted), 32'h1);
  endtask

  int cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    clear_rom();
    do_reset();
    #1;
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_dmem_req", 32'(dmem_req), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_outs", 32'({opcode, dmem_we, dmem_addr, dmem_wdata}), 32'h0);

    // 1: LDI/LDI/ADD/HALT
    rom[0] = ins(4'd8, 4'd1, 8'h05);
    rom[1] = ins(4'd8, 4'd2, 8'h03);
    rom[2] = ins(4'd1, 4'd3, 8'h12);
    rom[3] = ins(4'd15, 4'd0, 8'h00);
    run(0, cyc);
    check("t1_cycles", 32'(cyc), 32'd16);
    check("t1_r3", 32'(dut.regs[3]), 32'h08);
    check("t1_z", 32'(dut.flag_z), 32'h0);
    check("t1_c", 32'(dut.flag_c), 32'h0);
    check("t1_pc", 32'(pc), 32'h03);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_opcode", 32'(opcode), 32'hF);

    // 2: ADD carry/zero, then SUB borrow after restart from HALT
    clear_rom();
    rom[0] = ins(4'd8, 4'd1, 8'hFF);
    rom[1] = ins(4'd8, 4'd2, 8'h01);
    rom[2] = ins(4'd1, 4'd3, 8'h12);
    rom[3] = ins(4'd15, 4'd0, 8'h00);
    rom[4] = ins(4'd2, 4'd4, 8'h21);
    rom[5] = ins(4'd15, 4'd0, 8'h00);
    do_reset();
    run(0, cyc);
    check("t2_r3", 32'(dut.regs[3]), 32'h00);
    check("t2_add_z", 32'(dut.flag_z), 32'h1);
    check("t2_add_c", 32'(dut.flag_c), 32'h1);
    run(0, cyc);
    check("t2_restart_cycles", 32'(cyc), 32'd8);
    check("t2_restart_first_fetch", 32'(fa[0]), 32'h04);
    check("t2_r4", 32'(dut.regs[4]), 32'h02);
    check("t2_sub_c", 32'(dut.flag_c), 32'h1);
    check("t2_sub_z", 32'(dut.flag_z), 32'h0);
    check("t2_pc", 32'(pc), 32'h05);

    // 3: ST then LD with 3 wait states
    clear_rom();
    rom[0] = ins(4'd8, 4'd1, 8'hA5);
    rom[1] = ins(4'd7, 4'd1, 8'h40);
    rom[2] = ins(4'd6, 4'd5, 8'h40);
    rom[3] = ins(4'd15, 4'd0, 8'h00);
    do_reset();
    dly = 3;
    run(0, cyc);
    check("t3_cycles", 32'(cyc), 32'd24);
    check("t3_accesses", 32'(lens.size()), 32'd2);
    if (lens.size() == 2) begin
      check("t3_st_req_len", 32'(lens[0]), 32'd4);
      check("t3_ld_req_len", 32'(lens[1]), 32'd4);
    end
    check("t3_stable", 32'(unstable), 32'h0);
    check("t3_fetches", 32'(ft.size()), 32'd4);
    if (ft.size() == 4) begin
      check("t3_st_cycles", 32'(ft[2] - ft[1]), 32'd8);
      check("t3_ld_cycles", 32'(ft[3] - ft[2]), 32'd8);
    end
    check("t3_mem", 32'(dm[8'h40]), 32'hA5);
    check("t3_r5", 32'(dut.regs[5]), 32'hA5);
    dly = 0;

    // 4a: BEQZ taken/not taken, JMP from 0xFF
    clear_rom();
    rom[8'h00] = ins(4'd9, 4'd0, 8'h10);
    rom[8'h01] = ins(4'd15, 4'd0, 8'h00);
    rom[8'h10] = ins(4'd8, 4'd0, 8'h01);
    rom[8'h11] = ins(4'd9, 4'd0, 8'h20);
    rom[8'h12] = ins(4'd10, 4'd0, 8'hFE);
    rom[8'hFE] = ins(4'd0, 4'd0, 8'h00);
    rom[8'hFF] = ins(4'd10, 4'd0, 8'h00);
    do_reset();
    run(0, cyc);
    check("t4a_nfetch", 32'(fa.size()), 32'd8);
    if (fa.size() == 8)
      check("t4a_seq", {fa[0], fa[1], fa[2], fa[3]}, 32'h0010_1112);
    if (fa.size() == 8)
      check("t4a_seq2", {fa[4], fa[5], fa[6], fa[7]}, 32'hFEFF_0001);
    check("t4a_pc", 32'(pc), 32'h01);

    // 4b: plain PC wrap 0xFF -> 0x00
    clear_rom();
    rom[8'h00] = ins(4'd9, 4'd0, 8'h02);
    rom[8'h01] = ins(4'd15, 4'd0, 8'h00);
    rom[8'h02] = ins(4'd8, 4'd0, 8'h01);
    rom[8'h03] = ins(4'd10, 4'd0, 8'hFF);
    rom[8'hFF] = ins(4'd0, 4'd0, 8'h00);
    do_reset();
    run(0, cyc);
    check("t4b_nfetch", 32'(fa.size()), 32'd6);
    if (fa.size() == 6)
      check("t4b_seq", {fa[2], fa[3], fa[4], fa[5]}, 32'h03FF_0001);
    check("t4b_pc", 32'(pc), 32'h01);

    // 5: reset during a stalled store
    clear_rom();
    rom[0] = ins(4'd8, 4'd1, 8'h33);
    rom[1] = ins(4'd7, 4'd1, 8'h40);
    rom[2] = ins(4'd15, 4'd0, 8'h00);
    do_reset();
    dly = 10;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && !dmem_req; i++) @(negedge clk);
    check("t5_in_mem", 32'(dmem_req), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_dmem_req_drop", 32'(dmem_req), 32'h0);
    check("t5_pc", 32'(pc), 32'h0);
    check("t5_r1", 32'(dut.regs[1]), 32'h0);
    check("t5_idle", 32'({busy, halted, imem_req}), 32'h0);
    @(negedge clk);
    check("t5_store_abandoned", 32'(dm[8'h40]), 32'hA5);
    rst_n = 1'b1;
    dly = 0;
    run(0, cyc);
    check("t5_first_fetch", 32'(fa[0]), 32'h00);
    check("t5_store_done", 32'(dm[8'h40]), 32'h33);

    // 6: undefined opcode, start while busy, sticky illegal
    clear_rom();
    rom[0] = ins(4'd8, 4'd1, 8'h07);
    rom[1] = ins(4'hC, 4'd1, 8'h23);
    rom[2] = ins(4'd8, 4'd2, 8'h09);
    rom[3] = ins(4'd15, 4'd0, 8'h00);
    rom[4] = ins(4'd0, 4'd0, 8'h00);
    rom[5] = ins(4'd15, 4'd0, 8'h00);
    do_reset();
    run(6, cyc);
    check("t6_cycles", 32'(cyc), 32'd16);
    check("t6_nfetch", 32'(fa.size()), 32'd4);
    check("t6_illegal", 32'(illegal), 32'h1);
    check("t6_r1", 32'(dut.regs[1]), 32'h07);
    check("t6_r2", 32'(dut.regs[2]), 32'h09);
    check("t6_pc", 32'(pc), 32'h03);
    run(0, cyc);
    check("t6_pc2", 32'(pc), 32'h05);
    check("t6_illegal_sticky", 32'(illegal), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
